// File: rtl/ahb_lite_sdram_bridge_if.sv
// Bus bundle for the AHB-Lite to SDRAM bridge.
// Carries the AHB-Lite slave port and the word-wide req/ack memory port.
// The slave modport is the bridge view; the master modport is the view of
// whatever drives the AHB side and answers the memory port.
interface ahb_lite_sdram_bridge_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32
);
    logic              HSEL;
    logic [31:0]       HADDR;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [1:0]        HTRANS;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADYOUT;
    logic              HRESP;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/ahb_lite_sdram_bridge.sv
// AHB-Lite slave front end of the SDRAM subsystem.
// Accepts single transfers, inserts wait states, builds byte enables and
// issues one word request per transfer on the req/ack memory port.
// Illegal size/alignment combinations get a two-cycle ERROR response and
// never reach memory. All outputs come straight from flops.
module ahb_lite_sdram_bridge #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ahb_lite_sdram_bridge_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_RREQ  = 3'd2,
        ST_WREQ  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR1  = 3'd5,
        ST_ERR2  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic                hreadyout_q, hreadyout_d;
    logic                hresp_q, hresp_d;
    logic [DATA_W-1:0]   hrdata_q, hrdata_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                accept_s;
    logic                illegal_s;
    logic [3:0]          be_s;
    logic                unused_haddr_s;

    // Byte lanes touched by a transfer of the given size at the given offset.
    function automatic logic [3:0] calc_be(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            3'd0:    be = 4'b0001 << addr_lo;
            3'd1:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Sizes wider than a word and misaligned halfwords/words are refused.
    function automatic logic is_illegal(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ill;
        case (size)
            3'd0:    ill = 1'b0;
            3'd1:    ill = addr_lo[0];
            3'd2:    ill = (addr_lo != 2'b00);
            default: ill = 1'b1;
        endcase
        return ill;
    endfunction

    // A new transfer is only taken while the data phase of the previous one is over.
    assign accept_s  = bus.HSEL & bus.HREADY & bus.HTRANS[1] &
                       ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign illegal_s = is_illegal(bus.HSIZE, bus.HADDR[1:0]);
    assign be_s      = calc_be(bus.HSIZE, bus.HADDR[1:0]);

    // Address bits above the memory window alias and are deliberately dropped.
    assign unused_haddr_s = ^bus.HADDR[31:ADDR_W+2];

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept from IDLE/DONE, wait for mem_ack in the request states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (!accept_s) begin
                    state_d = ST_IDLE;
                end else if (illegal_s) begin
                    state_d = ST_ERR1;
                end else if (bus.HWRITE) begin
                    state_d = ST_WDATA;
                end else begin
                    state_d = ST_RREQ;
                end
            end
            ST_WDATA: state_d = ST_WREQ;
            ST_RREQ, ST_WREQ: begin
                if (bus.mem_ack) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ERR1:  state_d = ST_ERR2;
            ST_ERR2:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the state being entered.
    always_comb begin
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        hrdata_d    = hrdata_q;
        case (state_d)
            ST_WDATA: hreadyout_d = 1'b0;
            ST_RREQ, ST_WREQ: begin
                hreadyout_d = 1'b0;
                mem_req_d   = 1'b1;
            end
            ST_ERR1: begin
                hreadyout_d = 1'b0;
                hresp_d     = 1'b1;
            end
            ST_ERR2:  hresp_d = 1'b1;
            default:  hreadyout_d = 1'b1;
        endcase
        if (accept_s && !illegal_s) begin
            mem_we_d   = bus.HWRITE;
            mem_addr_d = bus.HADDR[ADDR_W+1:2];
            mem_be_d   = be_s;
        end else begin
            mem_we_d   = mem_we_q;
        end
        if (state_q == ST_WDATA) begin
            mem_wdata_d = bus.HWDATA;
        end else begin
            mem_wdata_d = mem_wdata_q;
        end
        if ((state_q == ST_RREQ) && bus.mem_ack) begin
            hrdata_d = bus.mem_rdata;
        end else begin
            hrdata_d = hrdata_q;
        end
    end

    // Output registers; reset clears them asynchronously so mem_req drops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
        end else begin
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = hrdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
